// File: rtl/regbank_wr_encoder_if.sv
// Request/grant bundle between the write-request sources and the register-bank
// write-port select: one-hot request lines in, registered index stream out.
interface regbank_wr_encoder_if #(
  parameter int NREG = 32,
  parameter int IDXW = 5
);
  logic [NREG-1:0] req;
  logic            out_valid;
  logic [IDXW-1:0] out_idx;
  logic            out_ready;
  logic [NREG-1:0] pending;
  logic            dup;

  modport slave (
    input  req, out_ready,
    output out_valid, out_idx, pending, dup
  );

  modport master (
    output req, out_ready,
    input  out_valid, out_idx, pending, dup
  );
endinterface

// File: rtl/regbank_wr_encoder.sv
// Latches one-hot write requests into a pending mask and grants one register
// index per cycle, round-robin from the slot after the previous grant.
module regbank_wr_encoder #(
  parameter int NREG = 32,
  parameter int IDXW = 5
) (
  input  logic                clk,
  input  logic                rst,
  regbank_wr_encoder_if.slave bus
);

  logic [NREG-1:0] pending;
  logic [IDXW-1:0] ptr;
  logic            out_valid;
  logic [IDXW-1:0] out_idx;
  logic            dup;

  logic            load;
  logic            hit;
  logic            found;
  logic [IDXW-1:0] sel;
  logic [IDXW-1:0] idx;
  logic [NREG-1:0] clr_mask;

  assign load = !out_valid || bus.out_ready;
  assign hit  = |pending;

  // NREG == 2**IDXW, so the IDXW-bit add wraps the scan naturally.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      idx = ptr + IDXW'(i);
      if (!found && pending[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

  assign clr_mask = (load && hit) ? (NREG'(1) << sel) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      pending   <= '0;
      ptr       <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      dup       <= 1'b0;
    end else begin
      // A request landing on the bit being granted re-arms it.
      pending <= (pending & ~clr_mask) | bus.req;
      dup     <= |(bus.req & pending & ~clr_mask);
      if (load) begin
        out_valid <= hit;
        if (hit) begin
          out_idx <= sel;
          ptr     <= sel + 1'b1;
        end
      end
    end
  end

  assign bus.out_valid = out_valid;
  assign bus.out_idx   = out_idx;
  assign bus.pending   = pending;
  assign bus.dup       = dup;

endmodule

// File: tb/tb_regbank_wr_encoder.sv
// Directed-vector bench for regbank_wr_encoder: latency, wrap burst,
// back-pressure, round-robin order, duplicate merge and mid-stream reset.
module tb_regbank_wr_encoder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;

  regbank_wr_encoder_if #(.NREG(32), .IDXW(5)) bus ();

  regbank_wr_encoder #(.NREG(32), .IDXW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.req       = '0;
    bus.out_ready = 1'b1;

    // reset state
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_idx",   32'(bus.out_idx),   32'd0);
    check("rst_pend",  bus.pending,        32'h0);
    check("rst_dup",   32'(bus.dup),       32'd0);
    check("rst_ptr",   32'(dut.ptr),       32'd0);

    // single request: two-cycle latency, one-cycle grant
    bus.req = 32'h0000_0080;
    step();
    bus.req = '0;
    check("single_pend",   bus.pending,        32'h80);
    check("single_nogrant",32'(bus.out_valid), 32'd0);
    step();
    check("single_valid",  32'(bus.out_valid), 32'd1);
    check("single_idx",    32'(bus.out_idx),   32'd7);
    check("single_clr",    bus.pending,        32'h0);
    step();
    check("single_drop",   32'(bus.out_valid), 32'd0);

    // burst with wrap from ptr 0
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.req = 32'hFFFF_FFFF;
    step();
    bus.req = '0;
    check("burst_pend", bus.pending, 32'hFFFF_FFFF);
    for (int k = 0; k < 32; k++) begin
      step();
      check("burst_valid", 32'(bus.out_valid), 32'd1);
      check("burst_idx",   32'(bus.out_idx),   32'(k));
    end
    step();
    check("burst_end_valid", 32'(bus.out_valid), 32'd0);
    check("burst_end_ptr",   32'(dut.ptr),       32'd0);
    check("burst_end_pend",  bus.pending,        32'h0);

    // back-pressure: 3 held, then 9
    bus.out_ready = 1'b0;
    bus.req = 32'h0000_0208;
    step();
    bus.req = '0;
    step();
    check("bp_valid", 32'(bus.out_valid), 32'd1);
    check("bp_idx",   32'(bus.out_idx),   32'd3);
    check("bp_pend",  bus.pending,        32'h200);
    for (int k = 0; k < 4; k++) begin
      step();
      check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
      check("bp_hold_idx",   32'(bus.out_idx),   32'd3);
      check("bp_hold_pend",  bus.pending,        32'h200);
    end
    bus.out_ready = 1'b1;
    step();
    check("bp_next_valid", 32'(bus.out_valid), 32'd1);
    check("bp_next_idx",   32'(bus.out_idx),   32'd9);
    step();
    check("bp_end_valid",  32'(bus.out_valid), 32'd0);
    check("bp_end_pend",   bus.pending,        32'h0);

    // round-robin: grant 5 (ptr -> 6), then {2,5} gives 2 then 5
    bus.req = 32'h0000_0020;
    step();
    bus.req = '0;
    step();
    check("rr_first_idx", 32'(bus.out_idx), 32'd5);
    check("rr_ptr",       32'(dut.ptr),     32'd6);
    step();
    bus.req = 32'h0000_0024;
    step();
    bus.req = '0;
    step();
    check("rr_a_valid", 32'(bus.out_valid), 32'd1);
    check("rr_a_idx",   32'(bus.out_idx),   32'd2);
    step();
    check("rr_b_valid", 32'(bus.out_valid), 32'd1);
    check("rr_b_idx",   32'(bus.out_idx),   32'd5);
    step();
    check("rr_end_valid", 32'(bus.out_valid), 32'd0);

    // duplicate: occupy the output with 0, then req[4] twice while stalled
    bus.out_ready = 1'b0;
    bus.req = 32'h0000_0001;
    step();
    bus.req = 32'h0000_0010;
    step();
    check("dup_none", 32'(bus.dup), 32'd0);
    step();
    bus.req = '0;
    check("dup_pulse", 32'(bus.dup),       32'd1);
    check("dup_idx0",  32'(bus.out_idx),   32'd0);
    check("dup_pend",  bus.pending,        32'h10);
    step();
    check("dup_clear", 32'(bus.dup),       32'd0);
    bus.out_ready = 1'b1;
    step();
    check("dup_grant_valid", 32'(bus.out_valid), 32'd1);
    check("dup_grant_idx",   32'(bus.out_idx),   32'd4);
    step();
    check("dup_once_valid",  32'(bus.out_valid), 32'd0);
    check("dup_once_pend",   bus.pending,        32'h0);

    // reset mid-stream with a grant presented and 0xF0 pending
    bus.out_ready = 1'b0;
    bus.req = 32'h0000_0001;
    step();
    bus.req = 32'h0000_00F0;
    step();
    bus.req = '0;
    check("mid_valid", 32'(bus.out_valid), 32'd1);
    check("mid_pend",  bus.pending,        32'hF0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_pend",  bus.pending,        32'h0);
    check("mid_rst_ptr",   32'(dut.ptr),       32'd0);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("mid_no_grant", 32'(bus.out_valid), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
